counter_arbiter: RTL and testbench

Shares a single `counter` instance between up to `requesters` clients that each need a one-shot delay. Grants the counter round-robin and loads the winner's delay as the counter's reload value. Starts the counter, waits for its overflow, then returns a one-cycle `done` pulse to the winner. Sits between client FSMs and one `counter` instantiated with `start_resets_counting=1`, autostart and autoreload inputs disabled, and its `reset` input tied low.

---
 rtl/counter_arbiter.sv | 146 ++++++++++++++
 tb/tb_counter_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_arbiter.sv
// Round-robin arbiter that lends one shared one-shot counter to several clients.
// Optional abort-on-request-drop behaviour is enabled by defining COUNTER_ARBITER_ABORT_EN.
module counter_arbiter #(
    parameter int requesters = 4,
    parameter int bitwidth   = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [requesters-1:0]          request,
    input  logic [requesters*bitwidth-1:0] delay,
    input  logic                           counter_overflow,
    output logic [requesters-1:0]          grant,
    output logic [requesters-1:0]          done,
    output logic                           busy,
    output logic [bitwidth-1:0]            counter_reload_value,
    output logic                           counter_start,
    output logic                           counter_stop
);

    localparam int PW = (requesters > 1) ? $clog2(requesters) : 1;
    localparam logic [PW:0]   REQ_N = (PW+1)'(requesters);
    localparam logic [PW-1:0] LAST  = PW'(requesters - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARM,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t          state_reg;
    logic [PW-1:0]   ptr_reg;
    logic [PW-1:0]   owner_reg;
    logic [bitwidth-1:0] delay_arr [requesters];
    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic            abort;

    genvar gi;
    generate
        for (gi = 0; gi < requesters; gi++) begin : g_delay
            assign delay_arr[gi] = delay[gi*bitwidth +: bitwidth];
        end
    endgenerate

    // Rotating priority scan: first requester at or above the pointer, with wrap.
    always_comb begin
        logic [PW:0] sum;
        sum       = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < requesters; i++) begin
            sum = {1'b0, ptr_reg} + (PW+1)'(i);
            if (sum >= REQ_N) begin
                sum = sum - REQ_N;
            end
            if (!win_found && request[sum[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = sum[PW-1:0];
            end
        end
    end

`ifdef COUNTER_ARBITER_ABORT_EN
    assign abort = (state_reg == ST_LOAD || state_reg == ST_ARM || state_reg == ST_WAIT)
                   && !request[owner_reg];
`else
    assign abort = 1'b0;
`endif

    function automatic logic [requesters-1:0] onehot(input logic [PW-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
        next_ptr = (idx == LAST) ? '0 : idx + 1'b1;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg            <= ST_IDLE;
            ptr_reg              <= '0;
            owner_reg            <= '0;
            grant                <= '0;
            done                 <= '0;
            busy                 <= 1'b0;
            counter_reload_value <= '0;
            counter_start        <= 1'b0;
            counter_stop         <= 1'b0;
        end else begin
            done          <= '0;
            counter_start <= 1'b0;
            counter_stop  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (win_found) begin
                        if (delay_arr[win_idx] != '0) begin
                            grant                <= onehot(win_idx);
                            busy                 <= 1'b1;
                            counter_reload_value <= delay_arr[win_idx];
                            counter_start        <= 1'b1;
                            owner_reg            <= win_idx;
                            state_reg            <= ST_LOAD;
                        end else begin
                            // A zero reload would never overflow, so answer without the counter.
                            done    <= onehot(win_idx);
                            ptr_reg <= next_ptr(win_idx);
                        end
                    end
                end
                ST_LOAD, ST_ARM, ST_WAIT: begin
                    if (abort) begin
                        counter_stop <= 1'b1;
                        grant        <= '0;
                        busy         <= 1'b0;
                        ptr_reg      <= next_ptr(owner_reg);
                        state_reg    <= ST_DONE;
                    end else if (state_reg == ST_LOAD) begin
                        state_reg <= ST_ARM;
                    end else if (state_reg == ST_ARM) begin
                        // Overflow may still be high from the previous run until the start lands.
                        if (!counter_overflow) begin
                            state_reg <= ST_WAIT;
                        end
                    end else if (counter_overflow) begin
                        done         <= onehot(owner_reg);
                        counter_stop <= 1'b1;
                        grant        <= '0;
                        busy         <= 1'b0;
                        ptr_reg      <= next_ptr(owner_reg);
                        state_reg    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed self-checking bench for counter_arbiter with a behavioural shared counter.
// Abort scenarios are exercised only when COUNTER_ARBITER_ABORT_EN is defined.
module tb_counter_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  request = '0;
    logic [31:0] delay = '0;
    logic        counter_overflow;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [7:0]  counter_reload_value;
    logic        counter_start;
    logic        counter_stop;

    int err_cnt = 0;
    int chk_cnt = 0;
    int viol    = 0;

    logic [7:0] m_cnt = '0;
    logic       m_ovf = 1'b0;
    logic       m_run = 1'b0;

    counter_arbiter #(.requesters(4), .bitwidth(8)) dut (
        .clock                (clock),
        .reset                (reset),
        .request              (request),
        .delay                (delay),
        .counter_overflow     (counter_overflow),
        .grant                (grant),
        .done                 (done),
        .busy                 (busy),
        .counter_reload_value (counter_reload_value),
        .counter_start        (counter_start),
        .counter_stop         (counter_stop)
    );

    always #5 clock = ~clock;

    // Shared counter: start clears and restarts, overflow stays high until the next start.
    assign counter_overflow = m_ovf;
    always @(posedge clock) begin
        if (counter_start) begin
            m_cnt <= '0;
            m_ovf <= 1'b0;
            m_run <= 1'b1;
        end else if (counter_stop) begin
            m_run <= 1'b0;
        end else if (m_run) begin
            if (m_cnt == counter_reload_value - 8'd1) begin
                m_ovf <= 1'b1;
                m_run <= 1'b0;
            end else begin
                m_cnt <= m_cnt + 8'd1;
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            if (counter_start && counter_stop) viol++;
            if (!$onehot0(grant)) viol++;
            if (busy != (grant != 4'd0)) viol++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            cyc++;
            if (done != 4'd0) return;
        end
        check_eq("done_seen", 32'(done != 4'd0), 32'd1);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int cyc;
        int owner;

        // Reset state
        tick();
        tick();
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_start", 32'(counter_start), 32'd0);
        check_eq("rst_stop", 32'(counter_stop), 32'd0);
        check_eq("rst_reload", 32'(counter_reload_value), 32'd0);
        reset = 1'b0;

        // Single client, delay 5: done lands 7 edges after the grant edge
        delay[0*8 +: 8] = 8'd5;
        request = 4'b0001;
        tick();
        check_eq("single_grant", 32'(grant), 32'h1);
        check_eq("single_start", 32'(counter_start), 32'd1);
        check_eq("single_busy", 32'(busy), 32'd1);
        check_eq("single_reload", 32'(counter_reload_value), 32'd5);
        tick();
        check_eq("single_start_len", 32'(counter_start), 32'd0);
        wait_done(cyc);
        check_eq("single_done", 32'(done), 32'h1);
        check_eq("single_latency", 32'(cyc + 1), 32'd7);
        check_eq("single_stop", 32'(counter_stop), 32'd1);
        check_eq("single_grant_clr", 32'(grant), 32'd0);
        request = 4'b0000;
        tick();
        check_eq("single_done_len", 32'(done), 32'd0);
        tick();
        check_eq("single_done_once", 32'(done), 32'd0);
        check_eq("single_idle_grant", 32'(grant), 32'd0);

        // Contention: order 0,1,2,3,0 with one idle cycle between owners
        do_reset();
        delay = {8'd3, 8'd3, 8'd3, 8'd3};
        request = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            owner = k % 4;
            check_eq($sformatf("cont_grant%0d", k), 32'(grant), 32'd1 << owner);
            wait_done(cyc);
            check_eq($sformatf("cont_done%0d", k), 32'(done), 32'd1 << owner);
            if (k == 4) request = 4'b0000;
            tick();
            check_eq($sformatf("cont_gap%0d", k), 32'(grant), 32'd0);
            if (k < 4) tick();
        end

        // Zero delay on client 2: immediate done, no counter activity
        delay[2*8 +: 8] = 8'd0;
        request = 4'b0100;
        tick();
        check_eq("zero_done", 32'(done), 32'h4);
        check_eq("zero_start", 32'(counter_start), 32'd0);
        check_eq("zero_grant", 32'(grant), 32'd0);
        check_eq("zero_reload_hold", 32'(counter_reload_value), 32'd3);
        request = 4'b0000;
        tick();
        check_eq("zero_done_len", 32'(done), 32'd0);
        check_eq("zero_start2", 32'(counter_start), 32'd0);

        // Delay change after grant is ignored until the next grant
        delay[1*8 +: 8] = 8'd4;
        request = 4'b0010;
        tick();
        check_eq("dchg_grant", 32'(grant), 32'h2);
        check_eq("dchg_reload", 32'(counter_reload_value), 32'd4);
        delay[1*8 +: 8] = 8'd9;
        wait_done(cyc);
        check_eq("dchg_done", 32'(done), 32'h2);
        check_eq("dchg_reload_run", 32'(counter_reload_value), 32'd4);
        request = 4'b0000;
        tick();
        tick();
        check_eq("dchg_reload_idle", 32'(counter_reload_value), 32'd4);
        request = 4'b0010;
        tick();
        check_eq("dchg_regrant", 32'(grant), 32'h2);
        check_eq("dchg_reload_new", 32'(counter_reload_value), 32'd9);
        wait_done(cyc);
        check_eq("dchg_done2", 32'(done), 32'h2);
        request = 4'b0000;
        tick();
        tick();

`ifdef COUNTER_ARBITER_ABORT_EN
        // Abort in WAIT
        delay = {8'd5, 8'd3, 8'd3, 8'd3};
        request = 4'b1000;
        tick();
        check_eq("abt1_grant", 32'(grant), 32'h8);
        tick();
        tick();
        tick();
        request = 4'b0101;
        tick();
        check_eq("abt1_stop", 32'(counter_stop), 32'd1);
        check_eq("abt1_nodone", 32'(done), 32'd0);
        check_eq("abt1_grant_clr", 32'(grant), 32'd0);
        tick();
        check_eq("abt1_nodone2", 32'(done), 32'd0);
        tick();
        check_eq("abt1_next", 32'(grant), 32'h1);
        wait_done(cyc);
        check_eq("abt1_next_done", 32'(done), 32'h1);
        request = 4'b0000;
        tick();
        tick();

        // Abort coinciding with overflow
        request = 4'b1000;
        tick();
        check_eq("abt2_grant", 32'(grant), 32'h8);
        for (int i = 0; i < 6; i++) tick();
        request = 4'b0101;
        tick();
        check_eq("abt2_stop", 32'(counter_stop), 32'd1);
        check_eq("abt2_nodone", 32'(done), 32'd0);
        check_eq("abt2_grant_clr", 32'(grant), 32'd0);
        tick();
        check_eq("abt2_nodone2", 32'(done), 32'd0);
        tick();
        check_eq("abt2_next", 32'(grant), 32'h1);
        wait_done(cyc);
        check_eq("abt2_next_done", 32'(done), 32'h1);
        request = 4'b0000;
        tick();
        tick();
`endif

        // Asynchronous reset in the middle of WAIT
        delay[0*8 +: 8] = 8'd5;
        request = 4'b0001;
        tick();
        check_eq("mrst_grant", 32'(grant), 32'h1);
        tick();
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check_eq("mrst_grant_clr", 32'(grant), 32'd0);
        check_eq("mrst_busy_clr", 32'(busy), 32'd0);
        check_eq("mrst_done_clr", 32'(done), 32'd0);
        #2;
        reset = 1'b0;
        tick();
        check_eq("mrst_regrant", 32'(grant), 32'h1);
        check_eq("mrst_start", 32'(counter_start), 32'd1);
        wait_done(cyc);
        check_eq("mrst_done", 32'(done), 32'h1);
        request = 4'b0000;
        tick();
        tick();

        check_eq("invariants", 32'(viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
